// File: rtl/window_loader.sv
// Window loader: fetches WIN_DIM x WIN_DIM pixels one address at a time
// and hands the raster-ordered window to the kernel over valid/ready.
module window_loader #(
  parameter int PIX_W   = 8,
  parameter int WIN_DIM = 5,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         i_enable,
  output logic                         o_inc_raddr,
  input  logic [ADDR_W-1:0]            i_raddr,
  input  logic                         i_r_ready,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic                         o_mem_read,
  input  logic [PIX_W-1:0]             i_mem_rdata,
  input  logic                         i_mem_rvalid,
  output logic [PIX_W*WIN_DIM*WIN_DIM-1:0] o_window,
  output logic                         o_win_valid,
  input  logic                         i_win_ready,
  output logic [15:0]                  o_win_count,
  output logic                         o_busy,
  output logic                         o_error
);

  localparam int NPIX = WIN_DIM * WIN_DIM;
  localparam int PC_W = $clog2(NPIX);
  localparam int TC_W = $clog2(TIMEOUT + 1);
  localparam logic [PC_W-1:0] LAST_PIX = PC_W'(NPIX - 1);
  localparam logic [TC_W-1:0] TC_MAX   = TC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ADDR,
    READ,
    WIN_OUT,
    ERROR
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PC_W-1:0] pix_cnt;
  logic [TC_W-1:0] tcnt;
  logic            tmo;
  logic            last_pix;

  assign tmo      = (tcnt == TC_MAX);
  assign last_pix = (pix_cnt == LAST_PIX);

  assign o_inc_raddr = (state == REQ);
  assign o_error     = (state == ERROR);
  assign o_busy      = (state != IDLE) && (state != ERROR);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (i_enable) state_nx = REQ;
      REQ:       state_nx = WAIT_ADDR;
      WAIT_ADDR: begin
        if (i_r_ready)  state_nx = READ;
        else if (tmo)   state_nx = ERROR;
      end
      READ: begin
        if (i_mem_rvalid) state_nx = last_pix ? WIN_OUT : REQ;
        else if (tmo)     state_nx = ERROR;
      end
      WIN_OUT: begin
        if (i_win_ready) state_nx = i_enable ? REQ : IDLE;
      end
      ERROR:     state_nx = ERROR;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      tcnt        <= '0;
      o_mem_addr  <= '0;
      o_mem_read  <= 1'b0;
      o_window    <= '0;
      o_win_valid <= 1'b0;
      o_win_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        REQ: tcnt <= '0;
        WAIT_ADDR: begin
          if (i_r_ready) begin
            o_mem_addr <= i_raddr;
            o_mem_read <= 1'b1;
            tcnt       <= '0;
          end else if (tmo) begin
            o_mem_read <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        READ: begin
          if (i_mem_rvalid) begin
            for (int k = 0; k < NPIX; k++) begin
              if (pix_cnt == PC_W'(k))
                o_window[PIX_W*k +: PIX_W] <= i_mem_rdata;
            end
            o_mem_read <= 1'b0;
            if (last_pix) begin
              pix_cnt     <= '0;
              o_win_valid <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end else if (tmo) begin
            o_mem_read <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WIN_OUT: begin
          if (i_win_ready) begin
            o_win_valid <= 1'b0;
            o_win_count <= o_win_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_loader.sv
// Scoreboard bench for window_loader: address-counter and memory models
// feed the DUT while expected addresses and pixels are queued and compared.
module tb_window_loader;
  localparam int PIX_W   = 8;
  localparam int WIN_DIM = 5;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int NPIX    = WIN_DIM * WIN_DIM;

  logic                    clk;
  logic                    n_rst;
  logic                    i_enable;
  logic                    o_inc_raddr;
  logic [ADDR_W-1:0]       i_raddr;
  logic                    i_r_ready;
  logic [ADDR_W-1:0]       o_mem_addr;
  logic                    o_mem_read;
  logic [PIX_W-1:0]        i_mem_rdata;
  logic                    i_mem_rvalid;
  logic [PIX_W*NPIX-1:0]   o_window;
  logic                    o_win_valid;
  logic                    i_win_ready;
  logic [15:0]             o_win_count;
  logic                    o_busy;
  logic                    o_error;

  window_loader #(
    .PIX_W(PIX_W), .WIN_DIM(WIN_DIM),
    .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_enable(i_enable),
    .o_inc_raddr(o_inc_raddr), .i_raddr(i_raddr),
    .i_r_ready(i_r_ready), .o_mem_addr(o_mem_addr),
    .o_mem_read(o_mem_read), .i_mem_rdata(i_mem_rdata),
    .i_mem_rvalid(i_mem_rvalid), .o_window(o_window),
    .o_win_valid(o_win_valid), .i_win_ready(i_win_ready),
    .o_win_count(o_win_count), .o_busy(o_busy),
    .o_error(o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_checks = 0;
  int m_errors = 0;

  int inc_pulses;
  int rv_cnt;
  int idx;
  int acnt;
  int mcnt;
  bit addr_en;
  logic prev_read;
  logic prev_valid;
  logic [ADDR_W-1:0] a;
  logic [PIX_W*NPIX-1:0] exp_win;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [PIX_W-1:0]  pix_q[$];

  // rows are 424 apart; each later window is shifted by 3
  function automatic logic [ADDR_W-1:0] gen_addr(int n);
    int p;
    p = n % NPIX;
    return ADDR_W'(1 + 424 * (p / WIN_DIM) + p % WIN_DIM + 3 * (n / NPIX));
  endfunction

  always @(negedge clk) begin
    if (!n_rst) begin
      acnt = 0;
      i_r_ready = 1'b0;
      inc_pulses = 0;
      idx = 0;
      exp_addr_q.delete();
    end else begin
      i_r_ready = 1'b0;
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) begin
          i_raddr = gen_addr(idx);
          exp_addr_q.push_back(i_raddr);
          idx++;
          i_r_ready = 1'b1;
        end
      end
      if (o_inc_raddr) begin
        inc_pulses++;
        if (addr_en) acnt = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (!n_rst) begin
      mcnt = 0;
      i_mem_rvalid = 1'b0;
      prev_read = 1'b0;
      prev_valid = 1'b0;
      rv_cnt = 0;
      pix_q.delete();
    end else begin
      i_mem_rvalid = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          i_mem_rdata = o_mem_addr[PIX_W-1:0];
          i_mem_rvalid = 1'b1;
          rv_cnt++;
        end
      end
      if (o_mem_read && !prev_read) begin
        m_checks++;
        if (exp_addr_q.size() == 0) begin
          m_errors++;
          $display("FAIL mem_addr: got %0d, no address was issued",
                   o_mem_addr);
        end else begin
          a = exp_addr_q.pop_front();
          if (o_mem_addr !== a) begin
            m_errors++;
            $display("FAIL mem_addr: got %0d, expected %0d",
                     o_mem_addr, a);
          end
          pix_q.push_back(a[PIX_W-1:0]);
        end
        mcnt = 2;
      end
      prev_read = o_mem_read;
      if (o_win_valid && !prev_valid) begin
        m_checks++;
        if (pix_q.size() < NPIX) begin
          m_errors++;
          $display("FAIL window: valid after %0d pixels, expected %0d",
                   pix_q.size(), NPIX);
          pix_q.delete();
        end else begin
          for (int k = 0; k < NPIX; k++)
            exp_win[PIX_W*k +: PIX_W] = pix_q.pop_front();
          if (o_window !== exp_win) begin
            m_errors++;
            $display("FAIL window: got %h, expected %h",
                     o_window, exp_win);
          end
        end
      end
      prev_valid = o_win_valid;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    i_enable = 1'b0;
    i_win_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic wait_win_valid(input int budget);
    int n;
    n = 0;
    while (!o_win_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!o_win_valid) begin
      errors++;
      $display("FAIL win_valid_wait: got 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_rv(input int target, input int budget);
    int n;
    n = 0;
    while (rv_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rv_cnt < target) begin
      errors++;
      $display("FAIL rvalid_wait: got %0d rvalids, expected %0d",
               rv_cnt, target);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    i_win_ready = 1'b1;
    @(negedge clk);
    i_win_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    i_enable = 1'b0;
    i_win_ready = 1'b0;
    i_raddr = '0;
    i_mem_rdata = '0;
    addr_en = 1'b1;
    #2;
    checks++;
    if ({o_inc_raddr, o_mem_read, o_win_valid, o_busy, o_error} !== 5'b0
        || o_mem_addr !== '0 || o_window !== '0 || o_win_count !== 16'd0)
    begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b addr=%0d cnt=%0d, expected 0",
               {o_inc_raddr, o_mem_read, o_win_valid, o_busy, o_error},
               o_mem_addr, o_win_count);
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_single_window();
    do_reset();
    i_enable = 1'b1;
    wait_win_valid(2000);
    checks++;
    if (inc_pulses != NPIX || rv_cnt != NPIX) begin
      errors++;
      $display("FAIL single_counts: got pulses=%0d rvalids=%0d, expected %0d",
               inc_pulses, rv_cnt, NPIX);
    end
    checks++;
    if (o_window[7:0] !== 8'h01) begin
      errors++;
      $display("FAIL slot0: got %h, expected 01", o_window[7:0]);
    end
    checks++;
    if (o_window[47:40] !== 8'hA9) begin
      errors++;
      $display("FAIL slot5: got %h, expected a9", o_window[47:40]);
    end
    checks++;
    if (o_window[199:192] !== 8'hA5) begin
      errors++;
      $display("FAIL slot24: got %h, expected a5", o_window[199:192]);
    end
  endtask

  task automatic test_backpressure();
    logic [PIX_W*NPIX-1:0] w;
    bit stable;
    w = o_window;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (o_window !== w || o_win_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable || inc_pulses != NPIX) begin
      errors++;
      $display("FAIL backpressure_hold: got stable=%0d pulses=%0d, expected 1 and %0d",
               stable, inc_pulses, NPIX);
    end
    handshake();
    checks++;
    if (o_win_count !== 16'd1 || o_win_valid !== 1'b0
        || o_inc_raddr !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_accept: got cnt=%0d valid=%b inc=%b, expected 1 0 1",
               o_win_count, o_win_valid, o_inc_raddr);
    end
  endtask

  task automatic test_enable_drop();
    wait_rv(NPIX + 10, 1000);
    i_enable = 1'b0;
    wait_win_valid(2000);
    checks++;
    if (inc_pulses != 2 * NPIX || rv_cnt != 2 * NPIX) begin
      errors++;
      $display("FAIL drop_counts: got pulses=%0d rvalids=%0d, expected %0d",
               inc_pulses, rv_cnt, 2 * NPIX);
    end
    handshake();
    repeat (5) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_win_count !== 16'd2
        || inc_pulses != 2 * NPIX) begin
      errors++;
      $display("FAIL drop_idle: got busy=%b cnt=%0d pulses=%0d, expected 0 2 %0d",
               o_busy, o_win_count, inc_pulses, 2 * NPIX);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    addr_en = 1'b0;
    i_enable = 1'b1;
    n = 0;
    while (!o_inc_raddr && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checks++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got error=%b, expected 0", o_error);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_error !== 1'b1 || o_mem_read !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit: got err=%b read=%b busy=%b, expected 1 0 0",
               o_error, o_mem_read, o_busy);
    end
    i_enable = 1'b0;
    repeat (10) @(negedge clk);
    i_enable = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (o_error !== 1'b1 || o_inc_raddr !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b inc=%b, expected 1 0",
               o_error, o_inc_raddr);
    end
    addr_en = 1'b1;
  endtask

  task automatic test_reset_during_read();
    int n;
    do_reset();
    i_enable = 1'b1;
    wait_rv(12, 1000);
    n = 0;
    while (!o_mem_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2;
    n_rst = 1'b0;
    i_enable = 1'b0;
    #1;
    checks++;
    if ({o_inc_raddr, o_mem_read, o_win_valid, o_busy, o_error} !== 5'b0
        || o_mem_addr !== '0 || o_window !== '0) begin
      errors++;
      $display("FAIL async_reset: got ctl=%b addr=%0d, expected 0",
               {o_inc_raddr, o_mem_read, o_win_valid, o_busy, o_error},
               o_mem_addr);
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    i_enable = 1'b1;
    wait_win_valid(2000);
    checks++;
    if (inc_pulses != NPIX || o_window[7:0] !== 8'h01) begin
      errors++;
      $display("FAIL restart: got pulses=%0d slot0=%h, expected %0d 01",
               inc_pulses, o_window[7:0], NPIX);
    end
    i_enable = 1'b0;
    handshake();
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_backpressure();
    test_enable_drop();
    test_timeout();
    test_reset_during_read();
    repeat (5) @(negedge clk);
    checks += m_checks;
    errors += m_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
